// File: rtl/cdb_arbiter_if.sv
// Producer-side and broadcast-side signals of the CDB arbiter.
// The arbiter uses the slave modport; the producers and consumers use the master modport.
interface cdb_arbiter_if #(
  parameter int unsigned ENTRY_W = 5
);
  logic               rdy_in;
  logic               roll_back;

  logic               alu_valid;
  logic               alu_ready;
  logic [ENTRY_W-1:0] alu_entry;
  logic [31:0]        alu_value;
  logic [31:0]        alu_pc;

  logic               lsb_valid;
  logic               lsb_ready;
  logic [ENTRY_W-1:0] lsb_entry;
  logic [31:0]        lsb_value;

  logic               cdb_valid;
  logic               cdb_src;
  logic [ENTRY_W-1:0] cdb_entry;
  logic [31:0]        cdb_value;
  logic [31:0]        cdb_pc;

  modport master (
    output rdy_in, roll_back,
    output alu_valid, alu_entry, alu_value, alu_pc,
    output lsb_valid, lsb_entry, lsb_value,
    input  alu_ready, lsb_ready,
    input  cdb_valid, cdb_src, cdb_entry, cdb_value, cdb_pc
  );

  modport slave (
    input  rdy_in, roll_back,
    input  alu_valid, alu_entry, alu_value, alu_pc,
    input  lsb_valid, lsb_entry, lsb_value,
    output alu_ready, lsb_ready,
    output cdb_valid, cdb_src, cdb_entry, cdb_value, cdb_pc
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Buffers ALU and LSB results in two small FIFOs and drains them round-robin
// onto a single registered common data bus, at most one broadcast per cycle.
module cdb_arbiter #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ENTRY_W = 5
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  cdb_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSB = 1'b1} src_e;

  logic [ENTRY_W-1:0] alu_entry_mem [DEPTH];
  logic [31:0]        alu_value_mem [DEPTH];
  logic [31:0]        alu_pc_mem    [DEPTH];
  logic [ENTRY_W-1:0] lsb_entry_mem [DEPTH];
  logic [31:0]        lsb_value_mem [DEPTH];

  logic [PTR_W-1:0]   alu_wr_q, alu_wr_d, alu_rd_q, alu_rd_d;
  logic [PTR_W-1:0]   lsb_wr_q, lsb_wr_d, lsb_rd_q, lsb_rd_d;
  logic [CNT_W-1:0]   alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
  src_e               last_q, last_d;

  logic               cdb_valid_q, cdb_valid_d;
  src_e               cdb_src_q, cdb_src_d;
  logic [ENTRY_W-1:0] cdb_entry_q, cdb_entry_d;
  logic [31:0]        cdb_value_q, cdb_value_d;
  logic [31:0]        cdb_pc_q, cdb_pc_d;

  logic active, flush;
  logic alu_push, lsb_push, alu_ne, lsb_ne, grant_alu, grant_lsb;

  assign active = bus.rdy_in && !bus.roll_back;
  assign flush  = bus.rdy_in && bus.roll_back;

  // Readiness looks only at the current count: a full FIFO refuses even while popping.
  assign bus.alu_ready = active && (alu_cnt_q != FULL);
  assign bus.lsb_ready = active && (lsb_cnt_q != FULL);
  assign alu_push      = bus.alu_valid && bus.alu_ready;
  assign lsb_push      = bus.lsb_valid && bus.lsb_ready;

  assign alu_ne    = (alu_cnt_q != '0);
  assign lsb_ne    = (lsb_cnt_q != '0);
  assign grant_alu = active && alu_ne && (!lsb_ne || (last_q == SRC_LSB));
  assign grant_lsb = active && lsb_ne && (!alu_ne || (last_q == SRC_ALU));

  always_comb begin
    alu_wr_d    = alu_wr_q;
    alu_rd_d    = alu_rd_q;
    alu_cnt_d   = alu_cnt_q;
    lsb_wr_d    = lsb_wr_q;
    lsb_rd_d    = lsb_rd_q;
    lsb_cnt_d   = lsb_cnt_q;
    last_d      = last_q;
    cdb_valid_d = 1'b0;
    cdb_src_d   = cdb_src_q;
    cdb_entry_d = cdb_entry_q;
    cdb_value_d = cdb_value_q;
    cdb_pc_d    = cdb_pc_q;
    if (flush) begin
      alu_wr_d  = '0;
      alu_rd_d  = '0;
      alu_cnt_d = '0;
      lsb_wr_d  = '0;
      lsb_rd_d  = '0;
      lsb_cnt_d = '0;
    end else begin
      if (alu_push)  alu_wr_d = alu_wr_q + PTR_W'(1);
      if (grant_alu) alu_rd_d = alu_rd_q + PTR_W'(1);
      if (lsb_push)  lsb_wr_d = lsb_wr_q + PTR_W'(1);
      if (grant_lsb) lsb_rd_d = lsb_rd_q + PTR_W'(1);
      alu_cnt_d = alu_cnt_q + CNT_W'(alu_push) - CNT_W'(grant_alu);
      lsb_cnt_d = lsb_cnt_q + CNT_W'(lsb_push) - CNT_W'(grant_lsb);
      if (grant_alu) begin
        cdb_valid_d = 1'b1;
        cdb_src_d   = SRC_ALU;
        cdb_entry_d = alu_entry_mem[alu_rd_q];
        cdb_value_d = alu_value_mem[alu_rd_q];
        cdb_pc_d    = alu_pc_mem[alu_rd_q];
        last_d      = SRC_ALU;
      end else if (grant_lsb) begin
        cdb_valid_d = 1'b1;
        cdb_src_d   = SRC_LSB;
        cdb_entry_d = lsb_entry_mem[lsb_rd_q];
        cdb_value_d = lsb_value_mem[lsb_rd_q];
        cdb_pc_d    = '0;
        last_d      = SRC_LSB;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      alu_wr_q    <= '0;
      alu_rd_q    <= '0;
      alu_cnt_q   <= '0;
      lsb_wr_q    <= '0;
      lsb_rd_q    <= '0;
      lsb_cnt_q   <= '0;
      last_q      <= SRC_LSB;
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= SRC_ALU;
      cdb_entry_q <= '0;
      cdb_value_q <= '0;
      cdb_pc_q    <= '0;
    end else begin
      alu_wr_q    <= alu_wr_d;
      alu_rd_q    <= alu_rd_d;
      alu_cnt_q   <= alu_cnt_d;
      lsb_wr_q    <= lsb_wr_d;
      lsb_rd_q    <= lsb_rd_d;
      lsb_cnt_q   <= lsb_cnt_d;
      last_q      <= last_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_src_q   <= cdb_src_d;
      cdb_entry_q <= cdb_entry_d;
      cdb_value_q <= cdb_value_d;
      cdb_pc_q    <= cdb_pc_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (alu_push) begin
      alu_entry_mem[alu_wr_q] <= bus.alu_entry;
      alu_value_mem[alu_wr_q] <= bus.alu_value;
      alu_pc_mem[alu_wr_q]    <= bus.alu_pc;
    end
    if (lsb_push) begin
      lsb_entry_mem[lsb_wr_q] <= bus.lsb_entry;
      lsb_value_mem[lsb_wr_q] <= bus.lsb_value;
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_src   = cdb_src_q;
  assign bus.cdb_entry = cdb_entry_q;
  assign bus.cdb_value = cdb_value_q;
  assign bus.cdb_pc    = cdb_pc_q;
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) between the ALU and the load/store buffer, the two producers that complete out of order. Each producer pushes results into its own small FIFO. A round-robin arbiter drains one result per cycle into a registered CDB broadcast that feeds the reservation station, the LSB and the ROB. The block replaces direct dual broadcasting and guarantees at most one broadcast per cycle.

## Interface
- DEPTH, 4, entries per source FIFO (power of two, ≥2)
- ENTRY_W, 5, ROB entry index width
- clk_in  input  1  system clock
- rst_n_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global ready; low pauses the block
- roll_back  input  1  misprediction flush
- alu_valid  input  1  ALU result offered
- alu_ready  output  1  ALU FIFO can accept
- alu_entry  input  ENTRY_W  ROB index of ALU result
- alu_value  input  32  ALU result value
- alu_pc  input  32  ALU next-pc / branch target
- lsb_valid  input  1  LSB result offered
- lsb_ready  output  1  LSB FIFO can accept
- lsb_entry  input  ENTRY_W  ROB index of LSB result
- lsb_value  input  32  load data (0 for stores)
- cdb_valid  output  1  broadcast valid, one-cycle pulse per result
- cdb_src  output  1  0 = ALU, 1 = LSB
- cdb_entry  output  ENTRY_W  broadcast ROB index
- cdb_value  output  32  broadcast value
- cdb_pc  output  32  broadcast pc; 0 when cdb_src = 1

## Operation
- Two independent circular FIFOs, DEPTH entries each. Each has read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- The ALU FIFO stores {entry, value, pc}. The LSB FIFO stores {entry, value}.
- Ready signals are combinational: x_ready = rdy_in && !roll_back && count_x != DEPTH.
- Push happens on a rising edge when x_valid && x_ready.
- A full FIFO refuses input even when it pops in the same cycle. There is no pass-through.
- Arbitration runs every cycle with rdy_in high and roll_back low:
  - Only one FIFO non-empty: that FIFO is granted.
  - Both non-empty: grant the source opposite to last_grant.
  - Neither non-empty: no grant.
- On a grant:
  - Pop the head of the granted FIFO.
  - Register the head fields onto the cdb_* outputs and set cdb_valid = 1.
  - Update last_grant to the granted source.
- With no grant, cdb_valid = 0. cdb_entry, cdb_value, cdb_pc and cdb_src hold their previous values.
- A push and a pop on the same FIFO in the same cycle are both honoured; the count is unchanged.
- roll_back (synchronous, checked when rdy_in is high):
  - Clear both FIFOs (pointers and counts to 0).
  - Force cdb_valid to 0.
  - Leave last_grant unchanged.
  - Discard any input offered in that cycle.
- rdy_in low: no pointer, count, last_grant or output-data change, and no push. cdb_valid is forced to 0 so a result is never broadcast twice. roll_back is ignored while rdy_in is low.
- Async reset (rst_n_in low):
  - Pointers and counts = 0, last_grant = 1 (LSB), so the ALU wins the first tie.
  - cdb_valid = 0, cdb_src = 0, cdb_entry = 0, cdb_value = 0, cdb_pc = 0.
  - Reset takes effect immediately, mid-operation included, and discards all buffered results.
- FIFO storage arrays need no reset.

## Timing
- Latency: a result pushed at edge N is broadcast with cdb_valid high from edge N+1 to edge N+2, provided it is at the head and wins arbitration.
- Throughput: one broadcast per cycle total.
- Under sustained dual load each source gets exactly every other cycle.
- alu_ready and lsb_ready fall combinationally with rdy_in or roll_back. Producers must hold valid and data until they see ready high at a clock edge.
- Worst-case wait for a result at a FIFO head: 1 cycle when both sources are busy.

## Test plan
- Reset then single ALU push {entry=3, value=0x1234, pc=0x100}: the next cycle has cdb_valid=1, cdb_src=0, cdb_entry=3, cdb_value=0x1234, cdb_pc=0x100; the cycle after has cdb_valid=0.
- Simultaneous ALU push (entry 1) and LSB push (entry 2) after reset: ALU entry 1 is broadcast first, then LSB entry 2 with cdb_pc=0. No cycle has two broadcasts.
- Fill the LSB FIFO with 4 pushes while holding rdy_in low during draining: lsb_ready=0 at count 4. After rdy_in returns high, the 4 broadcasts appear in push order, wrap-around included, with each entry broadcast exactly once.
- Continuous pushes on both sources for 16 cycles: broadcasts alternate ALU/LSB, and each source gets 8 grants within 16 cycles.
- 3 ALU results buffered, then roll_back for 1 cycle: cdb_valid=0 in that cycle and after it. No stale entry is ever broadcast, alu_ready=1 the cycle after, and a new push broadcasts normally.
- Deassert rst_n_in asynchronously between edges with 2 entries buffered: all outputs go to 0 immediately, and no broadcast occurs after release until a new push.
